// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam logic [3:0] ANODE_OFF = 4'b0000;
    localparam logic [3:0] ANODE_D0  = 4'b0001;
    localparam logic [3:0] ANODE_D1  = 4'b0010;
    localparam logic [3:0] ANODE_D2  = 4'b0100;
    localparam logic [3:0] ANODE_D3  = 4'b1000;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        case (idx)
            2'd0:    return ANODE_D0;
            2'd1:    return ANODE_D1;
            2'd2:    return ANODE_D2;
            default: return ANODE_D3;
        endcase
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] value, input logic [1:0] idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

    // A digit is a leading zero when it and every more significant digit are zero.
    function automatic logic leading_zero(input logic [15:0] value, input logic [1:0] idx);
        case (idx)
            2'd3:    return value[15:12] == 4'h0;
            2'd2:    return value[15:8] == 8'h00;
            2'd1:    return value[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot counter: counts 0..SCAN_DIV-1 per slot while running, held at 0 when cleared.
module scan_timer #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic in_blank,
    output logic slot_end,
    output logic last_next
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST      = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (run) begin
            count_next = (count == LAST) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // in_blank and last_next describe the upcoming cycle; slot_end is the current one.
    assign in_blank  = count_next < BLANK_LIM;
    assign last_next = count_next == LAST;
    assign slot_end  = run && (count == LAST);

endmodule

// File: rtl/display_scan_controller.sv
// Scan sequencer: paces digit slots with anode dead-time, double-buffers the
// displayed value through a valid/ready handshake and blanks leading zeros.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_En,
    input  logic [15:0] i_Data,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_Lzb,
    output logic [3:0]  o_Anodo,
    output logic [1:0]  o_Sel,
    output logic [3:0]  o_Digit,
    output logic        o_Frame,
    output state_t      o_State
);

    // Handshake: a word transfers on any rising edge where i_Valid && o_Ready;
    // o_Ready is low exactly while the pending register holds an undisplayed word.

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic [15:0] disp, disp_next, pend;
    logic        pend_full, pend_full_next;
    logic        in_blank, slot_end, last_next;
    logic        accept, boundary, transfer, suppress;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) u_timer (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .clear    (!i_En),
        .run      (state != IDLE),
        .in_blank (in_blank),
        .slot_end (slot_end),
        .last_next(last_next)
    );

    always_comb begin
        accept         = i_Valid && o_Ready;
        boundary       = slot_end && (idx == 2'(NUM_DIGITS - 1));
        transfer       = pend_full && (boundary || state == IDLE);
        pend_full_next = accept || (pend_full && !transfer);
        disp_next      = transfer ? pend : disp;
        state_next     = IDLE;
        idx_next       = 2'd0;
        if (i_En) begin
            state_next = in_blank ? BLANK : ON;
            idx_next   = slot_end ? idx + 2'd1 : idx;
        end
        suppress = i_Lzb && leading_zero(disp_next, idx_next);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            disp      <= 16'h0000;
            pend      <= 16'h0000;
            pend_full <= 1'b0;
            o_Ready   <= 1'b1;
            o_Anodo   <= ANODE_OFF;
            o_Digit   <= 4'h0;
            o_Frame   <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            disp      <= disp_next;
            if (accept) begin
                pend <= i_Data;
            end
            pend_full <= pend_full_next;
            o_Ready   <= !pend_full_next;
            o_Digit   <= nibble(disp_next, idx_next);
            o_Anodo   <= (state_next == ON && !suppress) ? anode_for(idx_next) : ANODE_OFF;
            o_Frame   <= last_next && (idx == 2'(NUM_DIGITS - 1));
        end
    end

    assign o_Sel   = idx;
    assign o_State = state;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: table vectors, directed corner sequences and
// random stimulus against a cycle-count based reference model.
module tb_display_scan_controller;
    import display_pkg::*;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst, en, valid, lzb;
    logic [15:0] data;
    logic        ready, frame;
    logic [3:0]  anodo, digit;
    logic [1:0]  sel;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: enabled-cycle count m_t gives slot and phase by plain division.
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_full;
    logic [3:0]  e_anodo, e_digit;
    logic [1:0]  e_sel;
    logic        e_ready, e_frame;

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] data;
        logic        lzb;
        int          ncyc;
        logic [3:0]  anodo;
        logic [1:0]  sel;
        logic [3:0]  digit;
        logic        ready;
        logic        frame;
    } vec_t;

    vec_t vecs[$];

    display_scan_controller #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .i_En   (en),
        .i_Data (data),
        .i_Valid(valid),
        .o_Ready(ready),
        .i_Lzb  (lzb),
        .o_Anodo(anodo),
        .o_Sel  (sel),
        .o_Digit(digit),
        .o_Frame(frame),
        .o_State(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_suppressed(input logic [15:0] v, input int k);
        return (k != 0) && ((v >> (4 * k)) == 16'h0000);
    endfunction

    task automatic model_edge();
        bit boundary, transfer, accept;
        int k, phase;
        if (rst) begin
            m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_full = 0;
        end else begin
            accept   = valid && !m_full;
            boundary = m_run && (m_t % SCAN_DIV == SCAN_DIV - 1) && ((m_t / SCAN_DIV) % 4 == 3);
            transfer = m_full && (boundary || !m_run);
            if (transfer) begin
                m_disp = m_pend;
                m_full = 0;
            end
            if (accept) begin
                m_pend = data;
                m_full = 1;
            end
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
            end
        end
        k       = m_run ? (m_t / SCAN_DIV) % 4 : 0;
        phase   = m_t % SCAN_DIV;
        e_sel   = 2'(k);
        e_digit = 4'((m_disp >> (4 * k)) & 16'h000F);
        e_anodo = (m_run && phase >= BLANK_CYC && !(lzb && m_suppressed(m_disp, k))) ? 4'(1 << k) : 4'h0;
        e_frame = m_run && (phase == SCAN_DIV - 1) && (k == 3);
        e_ready = !m_full;
    endtask

    task automatic check_outputs();
        check("anodo", 16'(anodo), 16'(e_anodo));
        check("sel", 16'(sel), 16'(e_sel));
        check("digit", 16'(digit), 16'(e_digit));
        check("ready", 16'(ready), 16'(e_ready));
        check("frame", 16'(frame), 16'(e_frame));
        check("idle_state", 16'(state_dbg == IDLE), 16'(!m_run));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Steps until o_Frame is seen, then once more across the frame boundary.
    task automatic wait_frame(input string name);
        int n = 0;
        while (frame !== 1'b1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL %s: no o_Frame within %0d cycles", name, 2 * FRAME);
        end
        step();
    endtask

    function automatic void add_vec(input int v_en, input int v_valid, input int v_data, input int v_lzb,
                                    input int v_ncyc, input int v_anodo, input int v_sel, input int v_digit,
                                    input int v_ready, input int v_frame);
        vec_t v;
        v.en    = 1'(v_en);
        v.valid = 1'(v_valid);
        v.data  = 16'(v_data);
        v.lzb   = 1'(v_lzb);
        v.ncyc  = v_ncyc;
        v.anodo = 4'(v_anodo);
        v.sel   = 2'(v_sel);
        v.digit = 4'(v_digit);
        v.ready = 1'(v_ready);
        v.frame = 1'(v_frame);
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0]  mask;
        logic [15:0] d;
        int          n;

        // load 1234 in IDLE, then one full frame plus one slot of scanning
        add_vec(0, 1, 'h1234, 0, 1, 0, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, 1, 0, 0, 4, 1, 0);
        add_vec(1, 0, 0, 0, 2, 0, 0, 4, 1, 0);
        add_vec(1, 0, 0, 0, 6, 1, 0, 4, 1, 0);
        add_vec(1, 0, 0, 0, 2, 0, 1, 3, 1, 0);
        add_vec(1, 0, 0, 0, 6, 2, 1, 3, 1, 0);
        add_vec(1, 0, 0, 0, 2, 0, 2, 2, 1, 0);
        add_vec(1, 0, 0, 0, 6, 4, 2, 2, 1, 0);
        add_vec(1, 0, 0, 0, 2, 0, 3, 1, 1, 0);
        add_vec(1, 0, 0, 0, 5, 8, 3, 1, 1, 0);
        add_vec(1, 0, 0, 0, 1, 8, 3, 1, 1, 1);
        add_vec(1, 0, 0, 0, 2, 0, 0, 4, 1, 0);
        add_vec(1, 0, 0, 0, 6, 1, 0, 4, 1, 0);

        rst = 1'b1; en = 1'b0; valid = 1'b0; lzb = 1'b0; data = '0;
        step();
        step();
        check("reset_anodo", 16'(anodo), 16'h0);
        check("reset_ready", 16'(ready), 16'h1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            en = vecs[i].en; valid = vecs[i].valid; data = vecs[i].data; lzb = vecs[i].lzb;
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                step();
                check($sformatf("vec%0d_anodo", i), 16'(anodo), 16'(vecs[i].anodo));
                check($sformatf("vec%0d_sel", i), 16'(sel), 16'(vecs[i].sel));
                check($sformatf("vec%0d_digit", i), 16'(digit), 16'(vecs[i].digit));
                check($sformatf("vec%0d_ready", i), 16'(ready), 16'(vecs[i].ready));
                check($sformatf("vec%0d_frame", i), 16'(frame), 16'(vecs[i].frame));
            end
        end

        // mid-frame load: current frame keeps 1234, ABCD from the next digit-0 slot
        valid = 1'b1; data = 16'hABCD;
        step();
        valid = 1'b0;
        check("midload_ready_low", 16'(ready), 16'h0);
        wait_frame("midload_wait");
        check("midload_new_digit", 16'(digit), 16'hD);
        check("midload_sel", 16'(sel), 16'h0);
        check("midload_ready_back", 16'(ready), 16'h1);

        // offer while pending is full is refused; the value offered after ready returns wins
        valid = 1'b1; data = 16'h5555;
        step();
        data = 16'h6666;
        wait_frame("busy_wait1");
        check("busy_first", 16'(digit), 16'h5);
        step();
        valid = 1'b0;
        wait_frame("busy_wait2");
        check("busy_second", 16'(digit), 16'h6);

        // leading-zero blanking with 0050, then 0000 accepted exactly on a boundary edge
        lzb = 1'b1; valid = 1'b1; data = 16'h0050;
        step();
        valid = 1'b0;
        wait_frame("lzb_wait1");
        mask = anodo;
        for (int c = 1; c < FRAME; c++) begin
            step();
            mask |= anodo;
        end
        check("lzb_0050_mask", 16'(mask), 16'h0003);
        valid = 1'b1; data = 16'h0000;
        step();
        valid = 1'b0;
        check("boundary_accept_pending", 16'(ready), 16'h0);
        wait_frame("lzb_wait2");
        mask = anodo;
        for (int c = 1; c < FRAME; c++) begin
            step();
            mask |= anodo;
        end
        check("lzb_0000_mask", 16'(mask), 16'h0001);
        lzb = 1'b0;

        // drop enable during the ON phase of digit 2, then restart
        n = 0;
        while (!(sel == 2'd2 && anodo != 4'h0) && n < 2 * FRAME) begin
            step();
            n++;
        end
        check("reach_digit2_on", 16'(n < 2 * FRAME), 16'h1);
        en = 1'b0;
        step();
        check("disable_anodo", 16'(anodo), 16'h0);
        check("disable_sel", 16'(sel), 16'h0);
        step();
        en = 1'b1;
        step();
        step();
        check("reenable_blank", 16'(anodo), 16'h0);
        step();
        check("reenable_first_on", 16'(anodo), 16'h1);

        // asynchronous reset mid-slot with a pending word
        valid = 1'b1; data = 16'h9999;
        step();
        valid = 1'b0;
        repeat (3) step();
        check("pend_full_before_reset", 16'(ready), 16'h0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_anodo", 16'(anodo), 16'h0);
        check("async_rst_sel", 16'(sel), 16'h0);
        check("async_rst_digit", 16'(digit), 16'h0);
        check("async_rst_ready", 16'(ready), 16'h1);
        check("async_rst_frame", 16'(frame), 16'h0);
        step();
        rst = 1'b0;
        repeat (FRAME + 4) step();
        check("post_reset_digit", 16'(digit), 16'h0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            en    = ($urandom_range(0, 99) != 0);
            valid = ($urandom_range(0, 3) == 0);
            d     = 16'($urandom);
            case ($urandom_range(0, 3))
                1: d[15:12] = 4'h0;
                2: d[15:8]  = 8'h00;
                3: d[15:4]  = 12'h000;
                default: ;
            endcase
            data = d;
            if ($urandom_range(0, 19) == 0) lzb = ~lzb;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
